// File: rtl/bcd_to_excess3_serial.sv
// Serial BCD-to-Excess-3 converter: LSB-first digit on X, Mealy Excess-3 bit on Z.
// Define CV_ERR_CHECK_EN to compile in invalid-digit (10..15) detection on Err.
module bcd_to_excess3_serial (
    input  logic Clk,
    input  logic Rst,
    input  logic X,
    output logic Z,
    output logic Done,
    output logic Err
);

    typedef enum logic [2:0] {
        S0   = 3'd0,
        S1C0 = 3'd1,
        S1C1 = 3'd2,
        S2C0 = 3'd3,
        S2C1 = 3'd4,
        S3C0 = 3'd5,
        S3C1 = 3'd6
    } state_t;

    state_t state;
    state_t state_next;
    logic   at_bit1;
    logic   at_bit2;
    logic   at_bit3;

    assign at_bit1 = (state == S1C0) || (state == S1C1);
    assign at_bit2 = (state == S2C0) || (state == S2C1);
    assign at_bit3 = (state == S3C0) || (state == S3C1);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // The carry of the serial +0011 add lives in the state encoding.
    always_comb begin
        state_next = S0;
        unique case (state)
            S0:      state_next = X ? S1C1 : S1C0;
            S1C0:    state_next = X ? S2C1 : S2C0;
            S1C1:    state_next = S2C1;
            S2C0:    state_next = S3C0;
            S2C1:    state_next = X ? S3C1 : S3C0;
            S3C0:    state_next = S0;
            S3C1:    state_next = S0;
            default: state_next = S0;
        endcase
    end

    always_comb begin
        Z = 1'b0;
        unique case (state)
            S0:      Z = ~X;
            S1C0:    Z = ~X;
            S1C1:    Z = X;
            S2C0:    Z = X;
            S2C1:    Z = ~X;
            S3C0:    Z = X;
            S3C1:    Z = ~X;
            default: Z = ~X;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Done <= 1'b0;
        end else begin
            Done <= at_bit3;
        end
    end

`ifdef CV_ERR_CHECK_EN
    logic [1:0] mid_bits;

    // Digit is >= 10 when bit 3 is set together with bit 2 or bit 1.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            mid_bits <= '0;
            Err      <= 1'b0;
        end else begin
            if (at_bit1) begin
                mid_bits[0] <= X;
            end
            if (at_bit2) begin
                mid_bits[1] <= X;
            end
            if (at_bit3) begin
                Err <= X & (mid_bits[1] | mid_bits[0]);
            end
        end
    end
`else
    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_excess3_serial.sv
// Directed self-checking bench for bcd_to_excess3_serial (honours CV_ERR_CHECK_EN).
module tb_bcd_to_excess3_serial;

    logic Clk;
    logic Rst;
    logic X;
    logic Z;
    logic Done;
    logic Err;

    int unsigned passed;
    int unsigned total;

`ifdef CV_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    bcd_to_excess3_serial dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .X    (X),
        .Z    (Z),
        .Done (Done),
        .Err  (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drives nbits of digit d LSB first; checks Z per bit, Done after each edge,
    // and Err after the bit-3 edge when nbits == 4.
    task automatic drive_digit(input logic [3:0] d, input logic [3:0] ez,
                               input logic eerr, input int unsigned nbits,
                               input string name);
        for (int unsigned i = 0; i < nbits; i++) begin
            X = d[i];
            @(negedge Clk);
            total++;
            if (Z !== ez[i])
                $display("FAIL %s z_bit%0d: got %b expected %b", name, i, Z, ez[i]);
            else
                passed++;
            @(posedge Clk);
            #1;
            total++;
            if (Done !== (i == 3))
                $display("FAIL %s done_bit%0d: got %b expected %b", name, i, Done, (i == 3));
            else
                passed++;
        end
        if (nbits == 4) begin
            total++;
            if (Err !== eerr)
                $display("FAIL %s err: got %b expected %b", name, Err, eerr);
            else
                passed++;
        end
    endtask

    task automatic test_reset;
        Rst = 1'b0;
        X   = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        total++;
        if (Done !== 1'b0 || Err !== 1'b0)
            $display("FAIL reset_flags: got done=%b err=%b expected 0 0", Done, Err);
        else
            passed++;
        for (int unsigned i = 0; i < 2; i++) begin
            X = i[0];
            #1;
            total++;
            if (Z !== ~X)
                $display("FAIL reset_z x=%b: got %b expected %b", X, Z, ~X);
            else
                passed++;
        end
        Rst = 1'b1;
    endtask

    task automatic test_valid_digits;
        logic [3:0] zexp [10];
        zexp = '{4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
        for (int unsigned d = 0; d < 10; d++) begin
            drive_digit(d[3:0], zexp[d], 1'b0, 4, $sformatf("valid_%0d", d));
        end
    endtask

    task automatic test_back_to_back;
        drive_digit(4'b0111, 4'b1010, 1'b0, 4, "stream_7");
        drive_digit(4'b1001, 4'b1100, 1'b0, 4, "stream_9");
    endtask

    task automatic test_invalid;
        drive_digit(4'b1011, 4'b1110, ERR_EN, 4, "invalid_11");
    endtask

    task automatic test_err_clear;
        drive_digit(4'b1111, 4'b0010, ERR_EN, 4, "errclr_15");
        drive_digit(4'b0010, 4'b0101, 1'b0, 4, "errclr_2");
    endtask

    task automatic test_reset_mid_digit;
        drive_digit(4'b1000, 4'b1011, 1'b0, 2, "mid_partial");
        Rst = 1'b0;
        X   = 1'b1;
        @(posedge Clk);
        #1;
        total++;
        if (Done !== 1'b0 || Err !== 1'b0)
            $display("FAIL mid_reset_flags: got done=%b err=%b expected 0 0", Done, Err);
        else
            passed++;
        Rst = 1'b1;
        drive_digit(4'b0000, 4'b0011, 1'b0, 4, "mid_fresh_0");
    endtask

    task automatic test_reset_priority;
        Rst = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            X = ~i[0];
            @(negedge Clk);
            total++;
            if (Z !== ~X || Done !== 1'b0 && i > 0)
                $display("FAIL prio_%0d: got z=%b done=%b expected z=%b done=0", i, Z, Done, ~X);
            else
                passed++;
            @(posedge Clk);
            #1;
        end
        total++;
        if (Done !== 1'b0 || Err !== 1'b0)
            $display("FAIL prio_flags: got done=%b err=%b expected 0 0", Done, Err);
        else
            passed++;
        Rst = 1'b1;
        drive_digit(4'b0101, 4'b1000, 1'b0, 4, "prio_after_5");
    endtask

    initial begin
        passed = 0;
        total  = 0;
        Rst    = 1'b0;
        X      = 1'b0;
        @(posedge Clk);
        #1;
        test_reset;
        test_valid_digits;
        test_back_to_back;
        test_invalid;
        test_err_clear;
        test_reset_mid_digit;
        test_reset_priority;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bcd_to_excess3_serial.md
# bcd_to_excess3_serial

Serial BCD-to-Excess-3 converter, the encoding-side counterpart of the lab's serial Excess-3-to-BCD converter. It accepts one BCD digit per four clocks, LSB first, on `X`. It emits the Excess-3 code (digit + 3) bit-serially on `Z` as a Mealy output in the same cycle as each input bit. Digits stream back-to-back without reset; completion and invalid-digit status are reported on registered flags.

## Interface
- No parameters.
- `Clk`  input  1  system clock; all state updates on rising edge.
- `Rst`  input  1  synchronous, active-low reset; sampled on rising edge of `Clk`.
- `X`    input  1  serial BCD bit, LSB first; sampled on rising edge.
- `Z`    output 1  serial Excess-3 bit; combinational from current state and `X` (Mealy).
- `Done` output 1  registered one-cycle pulse after the 4th bit of a digit is consumed.
- `Err`  output 1  registered invalid-digit flag (BCD value 10..15).

## Operation
- Function: for each 4-bit group, Z3..Z0 = (X3..X0 + 0011) mod 16, computed by serial ripple add LSB first. The carry out of bit 3 is discarded.
- FSM states (7):
  - `S0`: bit 0, no carry.
  - `S1C0`, `S1C1`: bit 1, carry 0/1.
  - `S2C0`, `S2C1`: bit 2, carry 0/1.
  - `S3C0`, `S3C1`: bit 3, carry 0/1.
- Per-bit logic (c = carry held in state):
  - bit 0 (addend 1): Z = ~X; next carry = X.
  - bit 1 (addend 1): Z = ~(X ^ c); next carry = X | c.
  - bit 2 (addend 0): Z = X ^ c; next carry = X & c.
  - bit 3 (addend 0): Z = X ^ c; next state `S0`.
- Transitions: `S0`→`S1Cx`→`S2Cx`→`S3Cx`→`S0`, one step per clock, unconditionally while `Rst`=1. There is no idle state: every clock with `Rst`=1 consumes a bit.
- Error tracking: a 2-bit side register holds input bits 1 and 2 of the current digit.
  - On the bit-3 clock, the next value of `Err` is X & (b2 | b1).
  - `Err` holds its value until the next bit-3 clock or reset.
- `Done` goes high for exactly one cycle after each `S3Cx`→`S0` transition.
- Reset (`Rst`=0 at a rising edge) takes priority over everything:
  - state returns to `S0`, the side register clears, `Err`=0, `Done`=0.
  - `X` is ignored on that edge, and any partial digit is discarded without a `Done` pulse.
- Reset values: state `S0`, `Done`=0, `Err`=0. `Z` = ~X while in reset/`S0` (combinational, not forced).

## Timing
- Latency from `X` to `Z` is 0 cycles (combinational through the state decode). `Z` is valid once `X` is stable; the bench samples `Z` at the falling edge after driving `X`.
- `X` must be stable around each rising edge; state advances on that edge.
- `Done` and `Err` are valid in the cycle the next digit's bit 0 is presented, aligned to the first rising edge after the bit-3 edge.
- Back-to-back digits: bit 0 of the next digit may be presented in the cycle immediately after bit 3 of the previous digit; no bubble is required.
- Reset mid-digit (e.g. after 2 bits): the next rising edge with `Rst`=1 consumes bit 0 of a fresh digit.

## Configuration
- `CV_ERR_CHECK_EN` defined: the side register and `Err` logic are compiled in as described above.
- `CV_ERR_CHECK_EN` undefined: the side register is omitted and `Err` is tied to 0. `Z` and `Done` behave identically in both builds, including for invalid digits, which still yield (value + 3) mod 16.

## Test plan
- Exhaustive valid digits: after reset, drive BCD 0..9 LSB first, one per 4 clocks. Required `Z` sequences are 0011..1100; e.g. 0101 → 1000, 1001 → 1100. `Err`=0 throughout.
- Streaming without reset: drive 0111 then 1001 back-to-back → `Z` = 1010 then 1100. `Done` pulses exactly twice, 4 cycles apart.
- Invalid digit: drive 1011 → `Z` = 1110 (bit order 0,1,1,1). With `CV_ERR_CHECK_EN`, `Err`=1 after bit 3; without it, `Err`=0.
- Err clear: drive 1111 then 0010 → `Err` sets after the first digit and clears after the second. `Z` for 1111 is 0010; `Z` for 0010 is 0101.
- Reset mid-digit: drive 2 bits of 1000, assert `Rst`=0 for one edge, then drive 0000 → `Z` = 0011. No `Done` pulse for the aborted digit; `Done`, `Err` and state are at reset values during reset.
- Reset priority: hold `Rst`=0 with `X` toggling for 3 edges → state stays `S0`, `Done`=0, and `Z` tracks ~X.
